// File: rtl/aclk_time_counter_if.sv
// Pulse/load bundle between the time generator, key controller and the current-time counter.
// The master side drives the pulse, load request and new digits; the slave side returns time and status pulses.
interface aclk_time_counter_if;
   logic       one_minute;
   logic       load_new_c;
   logic [3:0] new_current_time_ms_hr;
   logic [3:0] new_current_time_ls_hr;
   logic [3:0] new_current_time_ms_min;
   logic [3:0] new_current_time_ls_min;
   logic [3:0] current_time_ms_hr;
   logic [3:0] current_time_ls_hr;
   logic [3:0] current_time_ms_min;
   logic [3:0] current_time_ls_min;
   logic       reset_count;
   logic       load_err;
   logic       day_wrap;

   modport master (
      output one_minute,
      output load_new_c,
      output new_current_time_ms_hr,
      output new_current_time_ls_hr,
      output new_current_time_ms_min,
      output new_current_time_ls_min,
      input  current_time_ms_hr,
      input  current_time_ls_hr,
      input  current_time_ms_min,
      input  current_time_ls_min,
      input  reset_count,
      input  load_err,
      input  day_wrap
   );

   modport slave (
      input  one_minute,
      input  load_new_c,
      input  new_current_time_ms_hr,
      input  new_current_time_ls_hr,
      input  new_current_time_ms_min,
      input  new_current_time_ls_min,
      output current_time_ms_hr,
      output current_time_ls_hr,
      output current_time_ms_min,
      output current_time_ls_min,
      output reset_count,
      output load_err,
      output day_wrap
   );
endinterface

// File: rtl/aclk_time_counter.sv
// Purpose: 24-hour BCD HH:MM current-time counter with validated load and generator resync.
// Latency: 1 cycle from sampled one_minute/load_new_c to digits and status pulses.
// Backpressure: none; every edge is accepted, a load discards a coincident minute pulse.
module aclk_time_counter (
   input  logic               clk,
   input  logic               reset,
   aclk_time_counter_if.slave tc
);

   typedef struct packed {
      logic [3:0] ms_hr;
      logic [3:0] ls_hr;
      logic [3:0] ms_min;
      logic [3:0] ls_min;
   } hhmm_t;

   hhmm_t time_q;
   hhmm_t time_d;
   hhmm_t new_time;
   hhmm_t inc_time;
   logic  load_ok;
   logic  inc_wrap;
   logic  reset_count_q;
   logic  reset_count_d;
   logic  load_err_q;
   logic  load_err_d;
   logic  day_wrap_q;
   logic  day_wrap_d;

   assign new_time = {tc.new_current_time_ms_hr,  tc.new_current_time_ls_hr,
                      tc.new_current_time_ms_min, tc.new_current_time_ls_min};

   // Hour 2x is legal only up to 23; minutes stop at 59.
   always_comb begin
      load_ok = (new_time.ms_hr  <= 4'd2) &&
                (new_time.ls_hr  <= 4'd9) &&
                !((new_time.ms_hr == 4'd2) && (new_time.ls_hr > 4'd3)) &&
                (new_time.ms_min <= 4'd5) &&
                (new_time.ls_min <= 4'd9);
   end

   // Ripple-carry increment across all four digits within one cycle.
   always_comb begin
      inc_time = time_q;
      inc_wrap = 1'b0;
      if (time_q.ls_min == 4'd9) begin
         inc_time.ls_min = 4'd0;
         if (time_q.ms_min == 4'd5) begin
            inc_time.ms_min = 4'd0;
            if ((time_q.ms_hr == 4'd2) && (time_q.ls_hr == 4'd3)) begin
               inc_time.ms_hr = 4'd0;
               inc_time.ls_hr = 4'd0;
               inc_wrap       = 1'b1;
            end else if (time_q.ls_hr == 4'd9) begin
               inc_time.ls_hr = 4'd0;
               inc_time.ms_hr = time_q.ms_hr + 4'd1;
            end else begin
               inc_time.ls_hr = time_q.ls_hr + 4'd1;
            end
         end else begin
            inc_time.ms_min = time_q.ms_min + 4'd1;
         end
      end else begin
         inc_time.ls_min = time_q.ls_min + 4'd1;
      end
   end

   // Any load request, accepted or rejected, swallows the minute pulse of the same edge.
   always_comb begin
      time_d        = time_q;
      reset_count_d = 1'b0;
      load_err_d    = 1'b0;
      day_wrap_d    = 1'b0;
      if (tc.load_new_c) begin
         if (load_ok) begin
            time_d        = new_time;
            reset_count_d = 1'b1;
         end else begin
            load_err_d    = 1'b1;
         end
      end else if (tc.one_minute) begin
         time_d     = inc_time;
         day_wrap_d = inc_wrap;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         time_q        <= '0;
         reset_count_q <= 1'b0;
         load_err_q    <= 1'b0;
         day_wrap_q    <= 1'b0;
      end else begin
         time_q        <= time_d;
         reset_count_q <= reset_count_d;
         load_err_q    <= load_err_d;
         day_wrap_q    <= day_wrap_d;
      end
   end

   assign tc.current_time_ms_hr  = time_q.ms_hr;
   assign tc.current_time_ls_hr  = time_q.ls_hr;
   assign tc.current_time_ms_min = time_q.ms_min;
   assign tc.current_time_ls_min = time_q.ls_min;
   assign tc.reset_count         = reset_count_q;
   assign tc.load_err            = load_err_q;
   assign tc.day_wrap            = day_wrap_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: minute-of-day reference model feeding an expected/actual scoreboard.
module tb_aclk_time_counter;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   aclk_time_counter_if tc_if();

   aclk_time_counter dut (
      .clk   (clk),
      .reset (reset),
      .tc    (tc_if)
   );

   typedef struct packed {
      logic [15:0] t;
      logic        rc;
      logic        le;
      logic        dw;
   } obs_t;

   obs_t exp_q[$];
   obs_t act_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   mdl_min = 0;

   function automatic obs_t sample();
      obs_t o;
      o.t  = {tc_if.current_time_ms_hr, tc_if.current_time_ls_hr,
              tc_if.current_time_ms_min, tc_if.current_time_ls_min};
      o.rc = tc_if.reset_count;
      o.le = tc_if.load_err;
      o.dw = tc_if.day_wrap;
      return o;
   endfunction

   function automatic logic [15:0] enc(input int mm);
      int h;
      int m;
      h = mm / 60;
      m = mm % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   // Drive one cycle, predict its result from the minute-of-day model, capture the DUT result.
   task automatic cycle(input logic ld, input logic om, input logic [15:0] nt);
      obs_t e;
      int   h;
      int   m;
      logic ok;
      @(negedge clk);
      tc_if.load_new_c              = ld;
      tc_if.one_minute              = om;
      tc_if.new_current_time_ms_hr  = nt[15:12];
      tc_if.new_current_time_ls_hr  = nt[11:8];
      tc_if.new_current_time_ms_min = nt[7:4];
      tc_if.new_current_time_ls_min = nt[3:0];
      e = '0;
      if (ld) begin
         h  = int'(nt[15:12]) * 10 + int'(nt[11:8]);
         m  = int'(nt[7:4]) * 10 + int'(nt[3:0]);
         ok = (nt[15:12] <= 4'd9) && (nt[11:8] <= 4'd9) && (nt[7:4] <= 4'd9) &&
              (nt[3:0] <= 4'd9) && (h < 24) && (m < 60);
         if (ok) begin
            mdl_min = h * 60 + m;
            e.rc    = 1'b1;
         end else begin
            e.le    = 1'b1;
         end
      end else if (om) begin
         mdl_min = (mdl_min + 1) % 1440;
         e.dw    = (mdl_min == 0);
      end
      e.t = enc(mdl_min);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      act_q.push_back(sample());
   endtask

   task automatic test_reset();
      obs_t a;
      tc_if.load_new_c              = 1'b0;
      tc_if.one_minute              = 1'b0;
      tc_if.new_current_time_ms_hr  = 4'd0;
      tc_if.new_current_time_ls_hr  = 4'd0;
      tc_if.new_current_time_ms_min = 4'd0;
      tc_if.new_current_time_ls_min = 4'd0;
      #3;
      a = sample();
      checks++;
      if (a !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_state: got %h rc%b le%b dw%b, want 0000 rc0 le0 dw0", a.t, a.rc, a.le, a.dw);
      end
      @(negedge clk);
      reset = 1'b1;
      mdl_min = 0;
   endtask

   task automatic test_count();
      obs_t e;
      obs_t a;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL count: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
      a = sample();
      checks++;
      if (a.t !== 16'h0010) begin
         errors++;
         $display("FAIL count_final: got %h, want 0010", a.t);
      end
   endtask

   task automatic test_carry();
      obs_t        e;
      obs_t        a;
      logic [15:0] pts[4];
      pts = '{16'h1259, 16'h2359, 16'h0959, 16'h1959};
      foreach (pts[i]) begin
         cycle(1'b1, 1'b0, pts[i]);
         cycle(1'b0, 1'b1, 16'h0000);
         cycle(1'b0, 1'b0, 16'h0000);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL carry: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
   endtask

   task automatic test_invalid_load();
      obs_t        e;
      obs_t        a;
      logic [15:0] bad[3];
      bad = '{16'h2400, 16'h1960, 16'h0A00};
      cycle(1'b1, 1'b0, 16'h0815);
      foreach (bad[i]) begin
         cycle(1'b1, 1'b0, bad[i]);
         cycle(1'b0, 1'b0, 16'h0000);
      end
      cycle(1'b1, 1'b1, 16'h2400);
      cycle(1'b0, 1'b0, 16'h0000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL invalid_load: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
   endtask

   task automatic test_load_priority();
      obs_t e;
      obs_t a;
      cycle(1'b1, 1'b1, 16'h0730);
      cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL load_priority: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e;
      obs_t a;
      cycle(1'b1, 1'b0, 16'h1111);
      cycle(1'b1, 1'b0, 16'h2222);
      cycle(1'b1, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 16'h2500);
      cycle(1'b1, 1'b0, 16'h1234);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b1, 1'b0, 16'h2358);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL back_to_back: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t e;
      obs_t a;
      cycle(1'b1, 1'b0, 16'h1542);
      cycle(1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      tc_if.one_minute = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      a = sample();
      checks++;
      if (a !== obs_t'(0)) begin
         errors++;
         $display("FAIL async_reset: got %h rc%b le%b dw%b, want 0000 before edge", a.t, a.rc, a.le, a.dw);
      end
      @(posedge clk);
      #1;
      a = sample();
      checks++;
      if (a !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_hold: got %h rc%b le%b dw%b, want 0000", a.t, a.rc, a.le, a.dw);
      end
      @(negedge clk);
      tc_if.one_minute = 1'b0;
      reset   = 1'b1;
      mdl_min = 0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h0000);
      cycle(1'b0, 1'b0, 16'h0000);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL after_reset: got %h rc%b le%b dw%b, want %h rc%b le%b dw%b",
                     a.t, a.rc, a.le, a.dw, e.t, e.rc, e.le, e.dw);
         end
      end
      a = sample();
      checks++;
      if (a.t !== 16'h0003) begin
         errors++;
         $display("FAIL after_reset_final: got %h, want 0003", a.t);
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_carry();
      test_invalid_load();
      test_load_priority();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aclk_time_counter.md
# aclk_time_counter

Current-time counter of the alarm clock and the consumer of the time generator's pulse interface. It counts the time of day in four BCD digits, HH:MM in 24-hour format, advancing one minute per `one_minute` pulse. It accepts a new current time from the key/controller path. On every accepted load it issues `reset_count` back to the time generator, so the next minute starts at the load point. Outputs feed the display driver and the alarm comparator.

## Interface

Parameters: none. Digit encoding and 24-hour range are fixed.

Ports:
- `clk`  input  1  system clock, rising-edge active
- `reset`  input  1  asynchronous, active-low reset
- `one_minute`  input  1  minute pulse from the time generator, one `clk` wide; in fast-watch mode it is the second pulse
- `load_new_c`  input  1  request to load the new current time, sampled each edge
- `new_current_time_ms_hr`  input  4  tens of hours, BCD
- `new_current_time_ls_hr`  input  4  units of hours, BCD
- `new_current_time_ms_min`  input  4  tens of minutes, BCD
- `new_current_time_ls_min`  input  4  units of minutes, BCD
- `current_time_ms_hr`  output  4  tens of hours
- `current_time_ls_hr`  output  4  units of hours
- `current_time_ms_min`  output  4  tens of minutes
- `current_time_ls_min`  output  4  units of minutes
- `reset_count`  output  1  resynchronises the time generator after a load
- `load_err`  output  1  a load request was rejected as an invalid time
- `day_wrap`  output  1  time wrapped from 23:59 to 00:00

## Operation

- All outputs are registers. When `reset` is low, every output is 0 (time 00:00) regardless of `clk`.
- **Priority per edge:** `load_new_c` takes precedence over `one_minute`. A `one_minute` pulse in the same cycle as any load request, valid or invalid, is discarded.
- **Valid load** means all four conditions hold:
  - ms_hr ≤ 2
  - ls_hr ≤ 9
  - if ms_hr = 2, then ls_hr ≤ 3
  - ms_min ≤ 5 and ls_min ≤ 9
- **Valid load response:**
  - The four digits take the new values.
  - `reset_count` = 1 for exactly the next cycle.
  - `load_err` = 0.
- **Invalid load response:**
  - Time is unchanged.
  - `load_err` = 1 for the next cycle.
  - `reset_count` stays 0.
- **Increment** (on `one_minute` = 1 with no load):
  - ls_min: 9→0 with carry into ms_min, otherwise +1.
  - ms_min: 5→0 with carry into the hour on a carry-in, otherwise +1.
  - Hour carry: if hour = 23, go to 00 and assert `day_wrap`. Otherwise ls_hr 9→0 with ms_hr +1, else ls_hr +1.
- Digits never leave the legal range. Invalid BCD combinations are unreachable from reset.
- `one_minute` held high for N consecutive cycles advances the time N minutes; the block does no edge detection.
- `reset_count`, `load_err` and `day_wrap` are single-cycle pulses. Each is 0 in any cycle with no triggering event.

## Timing

- Latency from sampled input to visible output is 1 cycle for:
  - time update from `one_minute`
  - digit load from `load_new_c`
  - the `reset_count`, `load_err` and `day_wrap` pulses
- `day_wrap` is asserted in the same cycle the digits show 00:00.
- `reset_count` is asserted in the same cycle the loaded digits first appear. The time generator then clears its count on the following edge.
- Back-to-back loads on consecutive cycles are each evaluated independently. `reset_count` stays high across consecutive valid loads.
- Reset asserted mid-operation clears all state and any pending pulse immediately. The first count or load is taken on the first rising edge after `reset` returns high.
- No input handshake. Inputs must be stable around the sampling edge; new-time digits matter only when `load_new_c` = 1.

## Test plan

- Reset then 10 `one_minute` pulses → digits show 00:10 and `day_wrap` stays 0 throughout.
- Load 12:59, then one pulse:
  - `reset_count` = 1 for 1 cycle after the load.
  - The pulse yields 13:00, with ls_min, ms_min and ls_hr all updating in one edge.
- Load 23:59, then one pulse → 00:00 with `day_wrap` = 1 for exactly that cycle. Also check 09:59 → 10:00 and 19:59 → 20:00.
- Invalid loads 24:00, 19:60 and 0A:00 (ls_hr = 4'hA), each from a known time:
  - Time unchanged.
  - `load_err` = 1 for one cycle.
  - `reset_count` = 0.
- `load_new_c` with 07:30 and `one_minute` asserted in the same cycle → time 07:30, not 07:31. A pulse on the next cycle gives 07:31.
- `reset` pulled low at 15:42 with `one_minute` active:
  - Outputs go to 00:00 asynchronously, before the next edge.
  - After release, 3 pulses give 00:03.
